pixel_frame_writer: RTL and testbench



---
 rtl/pixel_pkg.sv | 31 +++
 rtl/pixel_fifo.sv | 49 ++++
 rtl/pixel_frame_writer.sv | 200 ++++++++++++++++++++
 tb/tb_pixel_frame_writer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel frame writer.
// PIXEL_FRAME_WRITER_DEPTH_TEST_EN adds a 16-bit depth field to each pixel beat.
package pixel_pkg;

  localparam int          H_RES       = 320;
  localparam int          V_RES       = 180;
  localparam logic [11:0] CLEAR_COLOR = 12'h000;
  localparam logic [15:0] DEPTH_FAR   = 16'hFFFF;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
`ifdef PIXEL_FRAME_WRITER_DEPTH_TEST_EN
    logic [15:0] z;
`endif
    rgb444_t     rgb;
  } pixel_beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } fw_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of pixel beats with registered read data.
// DEPTH must be a power of two so the pointers wrap naturally.
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int  DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  pixel_beat_t   wr_data,
  output pixel_beat_t   rd_data,
  output logic          full,
  output logic          empty,
  output logic [PTR_W:0] count
);

  pixel_beat_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A write into a full FIFO is legal when the same edge frees a slot.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
    if (do_pop)  rd_data     <= mem[rd_ptr];
  end

endmodule

// File: rtl/pixel_frame_writer.sv
// Framebuffer writer: clears the frame on frame_start, then drains filtered pixel beats into BRAM.
// Define PIXEL_FRAME_WRITER_DEPTH_TEST_EN for the z-buffered variant (z_in port, 3-stage drain).
module pixel_frame_writer #(
  parameter int          H_RES       = pixel_pkg::H_RES,
  parameter int          V_RES       = pixel_pkg::V_RES,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [11:0] CLEAR_COLOR = pixel_pkg::CLEAR_COLOR,
  localparam int         ADDR_W      = $clog2(H_RES * V_RES)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_start_in,
  input  logic [10:0]       x_in,
  input  logic [9:0]        y_in,
  input  logic [3:0]        r_in,
  input  logic [3:0]        g_in,
  input  logic [3:0]        b_in,
  input  logic              valid_in,
`ifdef PIXEL_FRAME_WRITER_DEPTH_TEST_EN
  input  logic [15:0]       z_in,
`endif
  output logic [ADDR_W-1:0] bram_addr_out,
  output logic [11:0]       bram_data_out,
  output logic              bram_we_out,
  output logic              clearing_out,
  output logic              overflow_out,
  output logic [ADDR_W:0]   pixels_written_out
);
  import pixel_pkg::*;

  localparam int                NPIX      = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [10:0] x, input logic [9:0] y);
    logic [31:0] lin;
    lin = 32'(y) * 32'(H_RES) + 32'(x);
    return lin[ADDR_W-1:0];
  endfunction

  fw_state_t         state;
  fw_state_t         state_nxt;
  logic [ADDR_W-1:0] clr_cnt;

  pixel_beat_t       beat_in;
  pixel_beat_t       beat_p0;
  logic              beat_ok;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  logic              vld_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  rgb444_t           rgb_p1;

  logic              vld_out;
  logic [ADDR_W-1:0] addr_out;
  logic [11:0]       data_out;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (frame_start_in || state != CLEAR) clr_cnt <= '0;
      else                                  clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (frame_start_in)                              state_nxt = CLEAR;
    else if (state == CLEAR && clr_cnt == LAST_ADDR) state_nxt = RUN;
  end

  always_comb begin
    clearing_out  = 1'b0;
    bram_we_out   = vld_out;
    bram_addr_out = vld_out ? addr_out : '0;
    bram_data_out = vld_out ? data_out : 12'h000;
    if (state == CLEAR) begin
      clearing_out  = 1'b1;
      bram_we_out   = 1'b1;
      bram_addr_out = clr_cnt;
      bram_data_out = CLEAR_COLOR;
    end
  end

  always_comb begin
    beat_in.x     = x_in;
    beat_in.y     = y_in;
    beat_in.rgb.r = r_in;
    beat_in.rgb.g = g_in;
    beat_in.rgb.b = b_in;
`ifdef PIXEL_FRAME_WRITER_DEPTH_TEST_EN
    beat_in.z     = z_in;
`endif
  end

  // Input filter and FIFO: off-screen beats vanish without trace.
  assign beat_ok   = valid_in && ({21'd0, x_in} < 32'(H_RES)) && ({22'd0, y_in} < 32'(V_RES));
  assign fifo_pop  = !fifo_empty && state != CLEAR && !frame_start_in;
  assign fifo_push = beat_ok && (!fifo_full || fifo_pop);
  assign fifo_drop = beat_ok && (fifo_count == CNT_W'(FIFO_DEPTH)) && !fifo_pop;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_in),
    .rst     (rst_in),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (beat_in),
    .rd_data (beat_p0),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Stage p0 -> p1: popped beat becomes a linear address; CLEAR entry kills it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= fifo_pop;
      vld_p1 <= vld_p0 && !frame_start_in && state != CLEAR;
    end
  end

  always_ff @(posedge clk_in) begin
    addr_p1 <= pix_addr(beat_p0.x, beat_p0.y);
    rgb_p1  <= beat_p0.rgb;
  end

`ifdef PIXEL_FRAME_WRITER_DEPTH_TEST_EN
  logic [15:0]       depth_mem [NPIX];
  logic [15:0]       depth_p1;
  logic [15:0]       z_p1;
  logic [15:0]       depth_cmp;
  logic              depth_accept;
  logic              vld_p2;
  logic [ADDR_W-1:0] addr_p2;
  rgb444_t           rgb_p2;
  logic [15:0]       z_p2;

  // The depth read for p1 happened before the p2 winner was stored, so forward it.
  assign depth_cmp    = (vld_p2 && addr_p2 == addr_p1) ? z_p2 : depth_p1;
  assign depth_accept = vld_p1 && (z_p1 < depth_cmp) && state != CLEAR && !frame_start_in;

  always_ff @(posedge clk_in) begin
    if (state == CLEAR)    depth_mem[clr_cnt] <= DEPTH_FAR;
    else if (depth_accept) depth_mem[addr_p1] <= z_p1;
    depth_p1 <= depth_mem[pix_addr(beat_p0.x, beat_p0.y)];
    z_p1     <= beat_p0.z;
  end

  // Stage p1 -> p2: depth compare decides whether the pixel reaches the framebuffer.
  always_ff @(posedge clk_in) begin
    if (rst_in) vld_p2 <= 1'b0;
    else        vld_p2 <= depth_accept;
  end

  always_ff @(posedge clk_in) begin
    addr_p2 <= addr_p1;
    rgb_p2  <= rgb_p1;
    z_p2    <= z_p1;
  end

  assign vld_out  = vld_p2;
  assign addr_out = addr_p2;
  assign data_out = rgb_p2;
`else
  assign vld_out  = vld_p1;
  assign addr_out = addr_p1;
  assign data_out = rgb_p1;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      overflow_out       <= 1'b0;
      pixels_written_out <= '0;
    end else begin
      if (fifo_drop)           overflow_out <= 1'b1;
      else if (frame_start_in) overflow_out <= 1'b0;
      if (frame_start_in)      pixels_written_out <= '0;
      else if (vld_out)        pixels_written_out <= sat_inc(pixels_written_out);
    end
  end

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Scoreboard bench for pixel_frame_writer: expected pixel writes are queued as beats are
// driven and matched against BRAM write cycles; clear sequence, overflow and reset checked inline.
module tb_pixel_frame_writer;
  import pixel_pkg::*;

  localparam int HR   = 320;
  localparam int VR   = 180;
  localparam int NPIX = HR * VR;

  typedef struct {
    logic [15:0] addr;
    logic [11:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        frame_start_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic [3:0]  r_in, g_in, b_in;
  logic        valid_in;
  logic [15:0] z_in;
  logic [15:0] bram_addr_out;
  logic [11:0] bram_data_out;
  logic        bram_we_out;
  logic        clearing_out;
  logic        overflow_out;
  logic [16:0] pixels_written_out;

  int  n_checks = 0;
  int  n_fails  = 0;
  int  exp_pw   = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  pixel_frame_writer #(
    .H_RES       (HR),
    .V_RES       (VR),
    .FIFO_DEPTH  (8),
    .CLEAR_COLOR (12'h000)
  ) dut (
    .clk_in             (clk),
    .rst_in             (rst_in),
    .frame_start_in     (frame_start_in),
    .x_in               (x_in),
    .y_in               (y_in),
    .r_in               (r_in),
    .g_in               (g_in),
    .b_in               (b_in),
    .valid_in           (valid_in),
`ifdef PIXEL_FRAME_WRITER_DEPTH_TEST_EN
    .z_in               (z_in),
`endif
    .bram_addr_out      (bram_addr_out),
    .bram_data_out      (bram_data_out),
    .bram_we_out        (bram_we_out),
    .clearing_out       (clearing_out),
    .overflow_out       (overflow_out),
    .pixels_written_out (pixels_written_out)
  );

  // Advance one clock and retire any pixel write against the scoreboard.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (bram_we_out && !clearing_out) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_write: addr=%0d data=%h, required no write", bram_addr_out, bram_data_out);
      end else begin
        e = exp_q.pop_front();
        if (bram_addr_out !== e.addr || bram_data_out !== e.data) begin
          n_fails++;
          $display("FAIL pixel_write: addr=%0d data=%h, required addr=%0d data=%h",
                   bram_addr_out, bram_data_out, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic set_beat(input int x, input int y, input logic [11:0] c, input logic v);
    x_in     = 11'(x);
    y_in     = 10'(y);
    r_in     = c[11:8];
    g_in     = c[7:4];
    b_in     = c[3:0];
    valid_in = v;
  endtask

  task automatic expect_pixel(input int x, input int y, input logic [11:0] c);
    wr_t e;
    e.addr = 16'(y * HR + x);
    e.data = c;
    exp_q.push_back(e);
    exp_pw++;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bram_we_out !== 1'b0 || bram_addr_out !== 16'd0 || bram_data_out !== 12'd0 ||
        clearing_out !== 1'b0 || overflow_out !== 1'b0 || pixels_written_out !== 17'd0) begin
      n_fails++;
      $display("FAIL reset_outputs: we=%b addr=%0d data=%h clr=%b ovf=%b pw=%0d, required all 0",
               bram_we_out, bram_addr_out, bram_data_out, clearing_out, overflow_out, pixels_written_out);
    end
    n_checks++;
    if (dut.state !== IDLE || dut.fifo_empty !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_state: state=%0d empty=%b, required state=IDLE empty=1", dut.state, dut.fifo_empty);
    end
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_single_beat();
    set_beat(100, 50, 12'hF0A, 1'b1);
    expect_pixel(100, 50, 12'hF0A);
    tick();
    valid_in = 1'b0;
    n_checks++;
    if (bram_we_out !== 1'b0) begin
      n_fails++;
      $display("FAIL latency_edge_n: we=%b, required 0", bram_we_out);
    end
    tick();
    n_checks++;
    if (bram_we_out !== 1'b0) begin
      n_fails++;
      $display("FAIL latency_edge_n1: we=%b, required 0", bram_we_out);
    end
    tick();
    n_checks++;
    if (bram_we_out !== 1'b1 || bram_addr_out !== 16'd16100 || bram_data_out !== 12'hF0A) begin
      n_fails++;
      $display("FAIL latency_edge_n2: we=%b addr=%0d data=%h, required we=1 addr=16100 data=f0a",
               bram_we_out, bram_addr_out, bram_data_out);
    end
    tick();
    n_checks++;
    if (bram_we_out !== 1'b0 || pixels_written_out !== 17'(exp_pw)) begin
      n_fails++;
      $display("FAIL single_write_once: we=%b pw=%0d, required we=0 pw=%0d", bram_we_out, pixels_written_out, exp_pw);
    end
  endtask

  task automatic test_filter();
    set_beat(320, 10, 12'h111, 1'b1);
    tick();
    set_beat(5, 180, 12'h222, 1'b1);
    tick();
    set_beat(319, 179, 12'h123, 1'b1);
    expect_pixel(319, 179, 12'h123);
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (pixels_written_out !== 17'(exp_pw) || overflow_out !== 1'b0) begin
      n_fails++;
      $display("FAIL filter_counts: pw=%0d ovf=%b, required pw=%0d ovf=0", pixels_written_out, overflow_out, exp_pw);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL filter_pending: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_clear_overflow();
    int cnt      = 0;
    int bad      = 0;
    int bad_addr = -1;
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    exp_pw = 0;
    while (clearing_out === 1'b1 && cnt < NPIX + 100) begin
      if (bram_we_out !== 1'b1 || bram_addr_out !== 16'(cnt) || bram_data_out !== 12'h000) begin
        if (bad == 0) bad_addr = cnt;
        bad++;
      end
      if (cnt == 8) begin
        n_checks++;
        if (overflow_out !== 1'b0 || dut.u_fifo.count !== 4'd8) begin
          n_fails++;
          $display("FAIL fifo_full_in_clear: ovf=%b count=%0d, required ovf=0 count=8", overflow_out, dut.u_fifo.count);
        end
      end
      if (cnt < 9) begin
        set_beat(cnt * 3, 7, 12'(cnt * 17 + 1), 1'b1);
        if (cnt < 8) expect_pixel(cnt * 3, 7, 12'(cnt * 17 + 1));
      end else begin
        valid_in = 1'b0;
      end
      tick();
      cnt++;
    end
    n_checks++;
    if (cnt != NPIX) begin
      n_fails++;
      $display("FAIL clear_length: %0d cycles, required %0d", cnt, NPIX);
    end
    n_checks++;
    if (bad != 0) begin
      n_fails++;
      $display("FAIL clear_sequence: %0d bad cycles, first at cycle %0d, required addr=cycle data=000 we=1", bad, bad_addr);
    end
    n_checks++;
    if (dut.state !== RUN || clearing_out !== 1'b0 || overflow_out !== 1'b1) begin
      n_fails++;
      $display("FAIL clear_exit: state=%0d clr=%b ovf=%b, required state=RUN clr=0 ovf=1",
               dut.state, clearing_out, overflow_out);
    end
    for (int i = 0; i < 14; i++) tick();
    n_checks++;
    if (exp_q.size() != 0 || pixels_written_out !== 17'(exp_pw)) begin
      n_fails++;
      $display("FAIL drain_after_clear: %0d missing pw=%0d, required 0 missing pw=%0d", exp_q.size(), pixels_written_out, exp_pw);
    end
  endtask

  task automatic test_back_to_back();
    int max_cnt = 0;
    int writes  = 0;
    int rises   = 0;
    logic prev  = 1'b0;
    for (int i = 0; i < 210; i++) begin
      if (i < 200) begin
        int x = int'($urandom_range(0, HR - 1));
        int y = int'($urandom_range(0, VR - 1));
        logic [11:0] c = 12'($urandom);
        set_beat(x, y, c, 1'b1);
        expect_pixel(x, y, c);
      end else begin
        valid_in = 1'b0;
      end
      tick();
      if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
      if (bram_we_out === 1'b1) writes++;
      if (bram_we_out === 1'b1 && !prev) rises++;
      prev = bram_we_out;
    end
    n_checks++;
    if (writes != 200 || rises != 1) begin
      n_fails++;
      $display("FAIL b2b_consecutive: writes=%0d bursts=%0d, required writes=200 bursts=1", writes, rises);
    end
    n_checks++;
    if (max_cnt > 2) begin
      n_fails++;
      $display("FAIL b2b_fifo_level: max count=%0d, required <=2", max_cnt);
    end
    n_checks++;
    if (exp_q.size() != 0 || pixels_written_out !== 17'(exp_pw) || overflow_out !== 1'b1) begin
      n_fails++;
      $display("FAIL b2b_totals: missing=%0d pw=%0d ovf=%b, required missing=0 pw=%0d ovf=1 (sticky)",
               exp_q.size(), pixels_written_out, overflow_out, exp_pw);
    end
  endtask

  task automatic test_reset_mid_clear();
    int guard = 0;
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    exp_pw = 0;
    n_checks++;
    if (overflow_out !== 1'b0 || pixels_written_out !== 17'd0 || clearing_out !== 1'b1 || bram_addr_out !== 16'd0) begin
      n_fails++;
      $display("FAIL frame_start_clears: ovf=%b pw=%0d clr=%b addr=%0d, required ovf=0 pw=0 clr=1 addr=0",
               overflow_out, pixels_written_out, clearing_out, bram_addr_out);
    end
    while (bram_addr_out !== 16'd500 && guard < 2000) begin
      tick();
      guard++;
    end
    frame_start_in = 1'b1;
    tick();
    frame_start_in = 1'b0;
    n_checks++;
    if (clearing_out !== 1'b1 || bram_addr_out !== 16'd0) begin
      n_fails++;
      $display("FAIL clear_restart: clr=%b addr=%0d, required clr=1 addr=0", clearing_out, bram_addr_out);
    end
    set_beat(10, 10, 12'hABC, 1'b1);
    tick();
    valid_in = 1'b0;
    guard = 0;
    while (bram_addr_out !== 16'd1000 && guard < 2000) begin
      tick();
      guard++;
    end
    n_checks++;
    if (bram_addr_out !== 16'd1000 || clearing_out !== 1'b1) begin
      n_fails++;
      $display("FAIL reach_addr_1000: addr=%0d clr=%b, required addr=1000 clr=1", bram_addr_out, clearing_out);
    end
    rst_in = 1'b1;
    tick();
    n_checks++;
    if (bram_we_out !== 1'b0 || clearing_out !== 1'b0 || dut.state !== IDLE || dut.fifo_empty !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_mid_clear: we=%b clr=%b state=%0d empty=%b, required we=0 clr=0 state=IDLE empty=1",
               bram_we_out, clearing_out, dut.state, dut.fifo_empty);
    end
    rst_in = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (exp_q.size() != 0 || pixels_written_out !== 17'd0) begin
      n_fails++;
      $display("FAIL after_reset_idle: missing=%0d pw=%0d, required missing=0 pw=0", exp_q.size(), pixels_written_out);
    end
  endtask

  initial begin
    rst_in         = 1'b1;
    frame_start_in = 1'b0;
    z_in           = 16'd0;
    set_beat(0, 0, 12'h000, 1'b0);
    repeat (3) tick();
    test_reset();
    test_single_beat();
    test_filter();
    test_clear_overflow();
    test_back_to_back();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
